// File: rtl/calci_core.sv
// Calculator responder: valid/ready request in, held-until-accepted response out.
// Single-cycle logic/add/sub ops; iterative shift-add multiply and restoring divide.
//
// state  | meaning
// IDLE   | ready for a request; latches operands on accept
// EXEC   | one multiply or divide step per cycle while the counter runs down
// DONE   | response presented; held until out_ready
module calci_core #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic [2:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic [1:0]           err
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_CARRY = 2'b01;
    localparam logic [1:0] ERR_DIV0  = 2'b10;
    localparam logic [1:0] ERR_ILL   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_mul;
    logic [2*WIDTH-1:0]   r_prod;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_divisor;

    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_sub;
    logic [2*WIDTH-1:0]   w_prod_nxt;
    logic [WIDTH:0]       w_div_trial;
    logic                 w_div_ge;
    logic [WIDTH:0]       w_div_diff;
    logic [WIDTH-1:0]     w_rem_nxt;
    logic [WIDTH-1:0]     w_quo_nxt;
    logic [2*WIDTH-1:0]   w_single_res;
    logic [1:0]           w_single_err;

    assign in_ready = (r_state == S_IDLE) && !rst;

    assign w_add = {1'b0, op_a} + {1'b0, op_b};
    assign w_sub = {1'b0, op_a} - {1'b0, op_b};

    assign w_prod_nxt = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

    // Remainder stays below the divisor, so the trial value never needs more than WIDTH+1 bits.
    assign w_div_trial = {r_rem, r_quo[WIDTH-1]};
    assign w_div_ge    = (w_div_trial >= {1'b0, r_divisor});
    assign w_div_diff  = w_div_trial - {1'b0, r_divisor};
    assign w_rem_nxt   = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_trial[WIDTH-1:0];
    assign w_quo_nxt   = {r_quo[WIDTH-2:0], w_div_ge};

    always_comb begin
        w_single_res = '0;
        w_single_err = ERR_OK;
        case (opcode)
            OP_ADD: begin
                w_single_res = {{(WIDTH-1){1'b0}}, w_add};
                w_single_err = w_add[WIDTH] ? ERR_CARRY : ERR_OK;
            end
            OP_SUB: begin
                w_single_res = {{WIDTH{1'b0}}, w_sub[WIDTH-1:0]};
                w_single_err = w_sub[WIDTH] ? ERR_CARRY : ERR_OK;
            end
            OP_MUL: w_single_res = '0;
            OP_DIV: begin
                w_single_res = {op_a, {WIDTH{1'b1}}};
                w_single_err = ERR_DIV0;
            end
            OP_AND: w_single_res = {{WIDTH{1'b0}}, op_a & op_b};
            OP_OR:  w_single_res = {{WIDTH{1'b0}}, op_a | op_b};
            OP_XOR: w_single_res = {{WIDTH{1'b0}}, op_a ^ op_b};
            default: w_single_err = ERR_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_is_mul  <= 1'b0;
            r_prod    <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            err       <= ERR_OK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (opcode == OP_MUL && op_b != '0) begin
                            r_state  <= S_EXEC;
                            r_cnt    <= CNT_W'(WIDTH);
                            r_is_mul <= 1'b1;
                            r_prod   <= '0;
                            r_mcand  <= {{WIDTH{1'b0}}, op_a};
                            r_mplier <= op_b;
                        end else if (opcode == OP_DIV && op_b != '0) begin
                            r_state   <= S_EXEC;
                            r_cnt     <= CNT_W'(WIDTH);
                            r_is_mul  <= 1'b0;
                            r_rem     <= '0;
                            r_quo     <= op_a;
                            r_divisor <= op_b;
                        end else begin
                            r_state   <= S_DONE;
                            out_valid <= 1'b1;
                            result    <= w_single_res;
                            err       <= w_single_err;
                        end
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_is_mul) begin
                        r_prod   <= w_prod_nxt;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                    end
                    // Last step: the counter hits zero on this edge and the result is taken from the step itself.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state   <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= r_is_mul ? w_prod_nxt : {w_rem_nxt, w_quo_nxt};
                        err       <= ERR_OK;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calci_core.sv
// Self-checking bench for calci_core: directed vector table, reset corner cases,
// and randomized requests compared against an arithmetic reference model.
module tb_calci_core;

    localparam int WIDTH = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   op_a;
    logic [7:0]   op_b;
    logic [2:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  result;
    logic [1:0]   err;

    int checks = 0;
    int errors = 0;

    calci_core #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        int          hold;
        bit          early;
        logic [15:0] exp_res;
        logic [1:0]  exp_err;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation definitions.
    task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] r, output logic [1:0] e, output int lat);
        int ia, ib, s;
        ia = int'(a);
        ib = int'(b);
        e = 2'd0;
        r = 16'd0;
        lat = 1;
        case (op)
            3'd0: begin s = ia + ib; r = 16'(s); e = (s > 255) ? 2'd1 : 2'd0; end
            3'd1: begin s = (ia - ib + 256) % 256; r = 16'(s); e = (ia < ib) ? 2'd1 : 2'd0; end
            3'd2: begin r = 16'(ia * ib); if (ib != 0) lat = WIDTH + 1; end
            3'd3: begin
                if (ib == 0) begin r = 16'(ia * 256 + 255); e = 2'd2; end
                else begin r = 16'((ia % ib) * 256 + ia / ib); lat = WIDTH + 1; end
            end
            3'd4: r = 16'(ia & ib);
            3'd5: r = 16'(ia | ib);
            3'd6: r = 16'(ia ^ ib);
            default: e = 2'd3;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int hold, input bit early,
                          output logic [15:0] r, output logic [1:0] e, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) chk({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        opcode    = op;
        op_a      = a;
        op_b      = b;
        out_ready = early;
        @(posedge clk); #1;
        in_valid = 1'b0;
        opcode   = 3'($urandom);
        op_a     = 8'($urandom);
        op_b     = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < WIDTH + 20) begin
            chk({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) chk({tag, "_resp_timeout"}, 32'(out_valid), 32'd1);
        r = result;
        e = err;
        chk({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                chk({tag, "_hold_result"}, 32'(result), 32'(r));
                chk({tag, "_hold_err"}, 32'(err), 32'(e));
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[$];
    logic [15:0] r, mr;
    logic [1:0]  e, me;
    int          lat, mlat;

    initial begin
        vecs.push_back('{3'd0, 8'hFF, 8'h01, 0, 1'b0, 16'h0100, 2'd1, 1});
        vecs.push_back('{3'd0, 8'h12, 8'h34, 1, 1'b0, 16'h0046, 2'd0, 1});
        vecs.push_back('{3'd1, 8'h03, 8'h05, 4, 1'b0, 16'h00FE, 2'd1, 1});
        vecs.push_back('{3'd1, 8'h05, 8'h03, 0, 1'b1, 16'h0002, 2'd0, 1});
        vecs.push_back('{3'd2, 8'hFF, 8'hFF, 0, 1'b1, 16'hFE01, 2'd0, 9});
        vecs.push_back('{3'd2, 8'h0D, 8'h00, 0, 1'b0, 16'h0000, 2'd0, 1});
        vecs.push_back('{3'd2, 8'h00, 8'h05, 2, 1'b0, 16'h0000, 2'd0, 9});
        vecs.push_back('{3'd3, 8'd200, 8'd7, 0, 1'b0, 16'h041C, 2'd0, 9});
        vecs.push_back('{3'd3, 8'h05, 8'h00, 1, 1'b0, 16'h05FF, 2'd2, 1});
        vecs.push_back('{3'd3, 8'h07, 8'hC8, 0, 1'b1, 16'h0700, 2'd0, 9});
        vecs.push_back('{3'd3, 8'hFF, 8'h01, 0, 1'b0, 16'h00FF, 2'd0, 9});
        vecs.push_back('{3'd4, 8'hF0, 8'h3C, 0, 1'b0, 16'h0030, 2'd0, 1});
        vecs.push_back('{3'd5, 8'hF0, 8'h3C, 0, 1'b0, 16'h00FC, 2'd0, 1});
        vecs.push_back('{3'd6, 8'hF0, 8'h3C, 0, 1'b0, 16'h00CC, 2'd0, 1});
        vecs.push_back('{3'd7, 8'hAB, 8'hCD, 0, 1'b0, 16'h0000, 2'd3, 1});

        // Reset held with a request already pending: accepted on the first edge after release.
        rst = 1'b1; in_valid = 1'b1; opcode = 3'd0; op_a = 8'hFF; op_b = 8'h01; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_result", 32'(result), 32'h0100);
        chk("first_err", 32'(err), 32'd1);
        chk("first_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("first_drop", 32'(out_valid), 32'd0);
        chk("first_ready_back", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hold, vecs[i].early, r, e, lat);
            chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].exp_res));
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Reset in the middle of a multiply discards it without a response.
        in_valid = 1'b1; opcode = 3'd2; op_a = 8'hFF; op_b = 8'hFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_rel_ready", 32'(in_ready), 32'd1);
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_no_resp", 32'(out_valid), 32'd0);
        run_op("post_xor", 3'd6, 8'hF0, 8'h3C, 0, 1'b0, r, e, lat);
        chk("post_xor_result", 32'(r), 32'h00CC);
        run_op("post_ill", 3'd7, 8'h12, 8'h34, 0, 1'b0, r, e, lat);
        chk("post_ill_result", 32'(r), 32'd0);
        chk("post_ill_err", 32'(e), 32'd3);

        for (int n = 0; n < 60; n++) begin
            logic [2:0] op;
            logic [7:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            model(op, a, b, mr, me, mlat);
            run_op($sformatf("rnd%0d", n), op, a, b, $urandom_range(0, 2), 1'($urandom_range(0, 1)), r, e, lat);
            chk($sformatf("rnd%0d_op%0d_result", n, op), 32'(r), 32'(mr));
            chk($sformatf("rnd%0d_op%0d_err", n, op), 32'(e), 32'(me));
            chk($sformatf("rnd%0d_op%0d_latency", n, op), 32'(lat), 32'(mlat));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
